uart_tx_arbiter: RTL

- Shares the single RS-232 transmit path between NUM_REQ byte producers (e.g. keyboard echo, switch-driven send, status reporter).
- Round-robin grants one requester at a time and latches its byte.
- Drives a one-cycle start pulse to the transmitter, then waits for its done pulse or a timeout.
- Enforces an idle gap between frames. Sits between the user-side send logic and the transmitter / baud-rate domain adapter.

---
 rtl/uart_tx_arbiter_if.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and transmitter-side signals of the UART transmit
// arbiter.
//   slave  : the arbiter's view. It receives req/req_data/tx_done and drives
//            req_ack/tx_data/tx_start/busy/grant_id/timeout_err.
//   master : the environment's view (requesters plus transmitter).
// Ports carried:
//   req[NUM_REQ]            level send request per requester
//   req_data[NUM_REQ*DATA_W] packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ack[NUM_REQ]        one-hot, one-cycle capture acknowledge
//   tx_data[DATA_W]         byte presented to the transmitter
//   tx_start                one-cycle start pulse to the transmitter
//   tx_done                 one-cycle frame-finished pulse from the transmitter
//   busy                    arbiter not idle
//   grant_id                index of the last granted requester
//   timeout_err             one-cycle pulse when a frame is abandoned
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_done;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic                      timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  req_ack, tx_data, tx_start, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output req_ack, tx_data, tx_start, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit path between NUM_REQ byte producers. A round-robin
// search picks one requester, its byte is latched and acknowledged, the
// transmitter gets a one-cycle start pulse, and the arbiter waits for tx_done
// (or abandons the frame after TIMEOUT_CYCLES). An idle gap of GAP_CYCLES is
// enforced after every frame.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester and transmitter handshakes)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // With no gap configured a finished frame returns straight to IDLE.
    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    logic [DATA_W-1:0]   req_bytes_s [NUM_REQ];
    logic [ID_W-1:0]     winner_s;
    logic                found_s;
    logic [ID_W:0]       sum_s;
    logic [ID_W:0]       idx_s;
    logic [ID_W:0]       nxt_s;

    // Unpack the flat request bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes_s[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: walk offsets from high to low so the requester
    // closest to the pointer (offset 0 first) is the last one written.
    always_comb begin
        winner_s = '0;
        sum_s    = '0;
        idx_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum_s    = {1'b0, ptr_q} + (ID_W + 1)'(i);
            idx_s    = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
            winner_s = bus.req[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : winner_s;
        end
        found_s = |bus.req;
        nxt_s   = {1'b0, winner_s} + (ID_W + 1)'(1);
    end

    // Next-state and registered-output logic of the frame FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        req_ack_d     = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    tx_data_d  = req_bytes_s[winner_s];
                    grant_id_d = winner_s;
                    req_ack_d  = NUM_REQ'(1) << winner_s;
                    ptr_d      = (nxt_s >= NUM_REQ_W) ? '0 : nxt_s[ID_W-1:0];
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // tx_start is registered, so it appears the cycle after START
                // and never overlaps the acknowledge pulse.
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving together with the timeout wins.
                if (bus.tx_done) begin
                    cnt_d   = '0;
                    state_d = AFTER_FRAME;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = AFTER_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            req_ack_q     <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            req_ack_q     <= req_ack_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ack     = req_ack_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
